assoc_cache_plru: RTL and testbench

Parametrised N-way set-associative, write-back, write-allocate cache with tree pseudo-LRU replacement, a valid/ready CPU-side request port and a blocking memory-side refill/writeback port. Successor to the fixed 4-set/4-way MRU cache in the CACHE area. Sits between a core load/store unit and the memory or bus adapter. One request is outstanding at a time.

---
 rtl/assoc_cache_pkg.sv | 28 ++
 rtl/plru_tree.sv | 40 ++++
 rtl/assoc_cache_plru.sv | 232 +++++++++++++++++++++++
 tb/tb_assoc_cache_plru.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/assoc_cache_pkg.sv
// Shared types and derived-width helpers for the set-associative PLRU cache.
package assoc_cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB,
    FILL,
    RESP
  } state_e;

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets);
    return addr_w - 2 - $clog2(sets);
  endfunction

  function automatic int way_w(input int ways);
    return $clog2(ways);
  endfunction

  function automatic int tree_w(input int ways);
    return ways - 1;
  endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU: heap-ordered node bits (node n has children 2n+1, 2n+2),
// bit 0 points the victim search at the lower half of that subtree.
module plru_tree
  import assoc_cache_pkg::*;
#(
  parameter  int WAYS   = 4,
  localparam int WAY_W  = way_w(WAYS),
  localparam int TREE_W = tree_w(WAYS)
) (
  input  logic [TREE_W-1:0] tree_bits,
  input  logic [WAY_W-1:0]  access_way,
  output logic [TREE_W-1:0] next_bits,
  output logic [WAY_W-1:0]  victim_way
);

  // A node sits on the access path when its position in its level equals
  // the way's prefix above that level.
  always_comb begin : update
    next_bits = tree_bits;
    for (int l = 0; l < WAY_W; l++) begin
      for (int k = 0; k < (1 << l); k++) begin
        if ((access_way >> (WAY_W - l)) == WAY_W'(k)) begin
          next_bits[(1 << l) - 1 + k] = ~access_way[WAY_W - 1 - l];
        end
      end
    end
  end

  always_comb begin : walk
    victim_way = '0;
    for (int l = 0; l < WAY_W; l++) begin
      for (int k = 0; k < (1 << l); k++) begin
        if ((victim_way >> (WAY_W - l)) == WAY_W'(k)) begin
          victim_way[WAY_W - 1 - l] = tree_bits[(1 << l) - 1 + k];
        end
      end
    end
  end

endmodule

// File: rtl/assoc_cache_plru.sv
// N-way set-associative write-back / write-allocate cache with tree PLRU,
// one outstanding request, blocking refill/writeback memory port.
//
// state  | meaning
// IDLE   | ready for a CPU request
// LOOKUP | tag compare; hits answer here, clean read misses start the refill
// WB     | write back dirty victim
// FILL   | refill request, then wait for refill data
// RESP   | miss response; write misses install data here
module assoc_cache_plru
  import assoc_cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SETS   = 4,
  parameter int WAYS   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata
);

  localparam int IDX_W  = index_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, SETS);
  localparam int WAY_W  = way_w(WAYS);
  localparam int TREE_W = tree_w(WAYS);

  state_e state_q, state_d;

  logic              we_q;
  logic [ADDR_W-3:0] line_q;
  logic [DATA_W-1:0] wdata_q;
  logic [WAY_W-1:0]  victim_q;
  logic              fill_issued_q;

  logic [DATA_W-1:0] data_q  [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [TREE_W-1:0] plru_q  [SETS];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WAYS-1:0]   hit_vec;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  inv_way;
  logic              any_inv;
  logic [WAY_W-1:0]  plru_victim;
  logic [WAY_W-1:0]  vic_sel;
  logic              vic_dirty;
  logic [WAY_W-1:0]  plru_way;
  logic [TREE_W-1:0] plru_next;
  logic [ADDR_W-1:0] miss_addr;
  logic [ADDR_W-1:0] wb_addr;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^req_addr[1:0];

  assign idx       = line_q[IDX_W-1:0];
  assign tag       = line_q[ADDR_W-3 -: TAG_W];
  assign miss_addr = {line_q, 2'b00};
  assign wb_addr   = {tag_q[idx][victim_q], idx, 2'b00};

  always_comb begin : lookup
    hit_vec = '0;
    hit_way = '0;
    inv_way = '0;
    any_inv = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
    // Descending scan so the lowest-index invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) begin
        inv_way = WAY_W'(w);
        any_inv = 1'b1;
      end
    end
  end

  assign hit       = |hit_vec;
  assign vic_sel   = any_inv ? inv_way : plru_victim;
  assign vic_dirty = valid_q[idx][vic_sel] && dirty_q[idx][vic_sel];
  assign plru_way  = (state_q == LOOKUP) ? hit_way : victim_q;

  plru_tree #(.WAYS(WAYS)) u_plru (
    .tree_bits (plru_q[idx]),
    .access_way(plru_way),
    .next_bits (plru_next),
    .victim_way(plru_victim)
  );

  always_comb begin : fsm
    state_d       = state_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_hit      = 1'b0;
    resp_rdata    = '0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          resp_valid = 1'b1;
          resp_hit   = 1'b1;
          resp_rdata = we_q ? wdata_q : data_q[idx][hit_way];
          state_d    = IDLE;
        end else if (vic_dirty) begin
          state_d = WB;
        end else if (we_q) begin
          state_d = RESP;
        end else begin
          // Clean read miss issues the refill without waiting for FILL.
          mem_req_valid = 1'b1;
          mem_req_addr  = miss_addr;
          state_d       = FILL;
        end
      end
      WB: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = wb_addr;
        mem_req_wdata = data_q[idx][victim_q];
        if (mem_req_ready) state_d = we_q ? RESP : FILL;
      end
      FILL: begin
        if (!fill_issued_q) begin
          mem_req_valid = 1'b1;
          mem_req_addr  = miss_addr;
        end else if (mem_resp_valid) begin
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = we_q ? wdata_q : data_q[idx][victim_q];
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      line_q        <= '0;
      wdata_q       <= '0;
      victim_q      <= '0;
      fill_issued_q <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            line_q  <= req_addr[ADDR_W-1:2];
            wdata_q <= req_wdata;
          end
        end
        LOOKUP: begin
          fill_issued_q <= mem_req_valid && mem_req_ready;
          if (hit) begin
            plru_q[idx] <= plru_next;
            if (we_q) dirty_q[idx][hit_way] <= 1'b1;
          end else begin
            victim_q <= vic_sel;
          end
        end
        FILL: begin
          if (!fill_issued_q) begin
            fill_issued_q <= mem_req_ready;
          end else if (mem_resp_valid) begin
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= 1'b0;
          end
        end
        RESP: begin
          plru_q[idx] <= plru_next;
          if (we_q) begin
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage carries no reset; valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (state_q == LOOKUP && hit && we_q) begin
      data_q[idx][hit_way] <= wdata_q;
    end
    if (state_q == FILL && fill_issued_q && mem_resp_valid) begin
      data_q[idx][victim_q] <= mem_resp_rdata;
      tag_q[idx][victim_q]  <= tag;
    end
    if (state_q == RESP && we_q) begin
      data_q[idx][victim_q] <= wdata_q;
      tag_q[idx][victim_q]  <= tag;
    end
  end

endmodule

// File: tb/tb_assoc_cache_plru.sv
// Directed bench: instance 0 is the default 4x4 cache, instance 1 is 8 sets x 2 ways.
module tb_assoc_cache_plru;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst            [2];
  logic        req_valid      [2];
  logic        req_we         [2];
  logic [31:0] req_addr       [2];
  logic [31:0] req_wdata      [2];
  logic        mem_req_ready  [2];
  logic        mem_resp_valid [2];
  logic [31:0] mem_resp_rdata [2];
  wire         req_ready      [2];
  wire         resp_valid     [2];
  wire  [31:0] resp_rdata     [2];
  wire         resp_hit       [2];
  wire         mem_req_valid  [2];
  wire         mem_req_we     [2];
  wire  [31:0] mem_req_addr   [2];
  wire  [31:0] mem_req_wdata  [2];

  assoc_cache_plru dut (
    .clk(clk), .reset(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_hit(resp_hit[0]),
    .mem_req_valid(mem_req_valid[0]), .mem_req_ready(mem_req_ready[0]),
    .mem_req_we(mem_req_we[0]), .mem_req_addr(mem_req_addr[0]),
    .mem_req_wdata(mem_req_wdata[0]),
    .mem_resp_valid(mem_resp_valid[0]), .mem_resp_rdata(mem_resp_rdata[0])
  );

  assoc_cache_plru #(.SETS(8), .WAYS(2)) dut2 (
    .clk(clk), .reset(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_hit(resp_hit[1]),
    .mem_req_valid(mem_req_valid[1]), .mem_req_ready(mem_req_ready[1]),
    .mem_req_we(mem_req_we[1]), .mem_req_addr(mem_req_addr[1]),
    .mem_req_wdata(mem_req_wdata[1]),
    .mem_resp_valid(mem_resp_valid[1]), .mem_resp_rdata(mem_resp_rdata[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mv(input logic [31:0] a);
    return 32'hC0DE_0000 | a;
  endfunction

  task automatic check_idle_outputs(input int u, input string tag);
    check_eq({tag, "_ctl"},
             {59'd0, req_ready[u], resp_valid[u], resp_hit[u], mem_req_valid[u], mem_req_we[u]},
             64'b10000);
    check_eq({tag, "_data"}, {resp_rdata[u], mem_req_addr[u] | mem_req_wdata[u]}, 64'd0);
  endtask

  task automatic do_reset(input int u);
    @(negedge clk);
    rst[u] = 1'b1;
    @(negedge clk);
    rst[u] = 1'b0;
  endtask

  task automatic wait_mem(input int u, output int cyc);
    cyc = 0;
    while (mem_req_valid[u] !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("mem_req_seen", mem_req_valid[u], 1'b1);
  endtask

  task automatic wait_resp(input int u, output int cyc, output int mem_seen);
    cyc = 0;
    mem_seen = 0;
    while (resp_valid[u] !== 1'b1 && cyc < 50) begin
      if (mem_req_valid[u] === 1'b1) mem_seen++;
      @(negedge clk);
      cyc++;
    end
    if (mem_req_valid[u] === 1'b1) mem_seen++;
    check_eq("resp_seen", resp_valid[u], 1'b1);
  endtask

  // Called at a negedge with mem_req_valid high; returns one cycle after the handshake edge.
  task automatic handshake(input int u, input int stall);
    logic [31:0] a0;
    a0 = mem_req_addr[u];
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_eq("stall_hold", {mem_req_valid[u], mem_req_addr[u], req_ready[u]}, {1'b1, a0, 1'b0});
    end
    mem_req_ready[u] = 1'b1;
    @(negedge clk);
    mem_req_ready[u] = 1'b0;
  endtask

  task automatic access(input int u, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit exp_hit, input logic [31:0] exp_rdata,
                        input bit exp_wb, input logic [31:0] wb_addr, input logic [31:0] wb_data,
                        input bit exp_fill, input int stall);
    int cyc;
    int seen;
    @(negedge clk);
    check_eq("req_ready", req_ready[u], 1'b1);
    req_valid[u] = 1'b1;
    req_we[u]    = we;
    req_addr[u]  = addr;
    req_wdata[u] = wdata;
    @(negedge clk);
    req_valid[u] = 1'b0;
    if (exp_wb) begin
      wait_mem(u, cyc);
      check_eq("wb_we", mem_req_we[u], 1'b1);
      check_eq("wb_addr", mem_req_addr[u], wb_addr);
      check_eq("wb_data", mem_req_wdata[u], wb_data);
      handshake(u, 0);
    end
    if (exp_fill) begin
      wait_mem(u, cyc);
      if (!exp_wb) check_eq("clean_miss_lat", cyc, 0);
      check_eq("fill_we", mem_req_we[u], 1'b0);
      check_eq("fill_addr", mem_req_addr[u], addr);
      handshake(u, stall);
      mem_resp_valid[u] = 1'b1;
      mem_resp_rdata[u] = exp_rdata;
      @(negedge clk);
      mem_resp_valid[u] = 1'b0;
      mem_resp_rdata[u] = 32'h0;
      check_eq("fill_resp_lat", resp_valid[u], 1'b1);
    end else begin
      wait_resp(u, cyc, seen);
      check_eq("no_mem_traffic", seen, 0);
      if (exp_hit) check_eq("hit_lat", cyc, 0);
    end
    check_eq("resp_rdata", resp_rdata[u], exp_rdata);
    check_eq("resp_hit", resp_hit[u], exp_hit);
    @(negedge clk);
    check_eq("resp_pulse", resp_valid[u], 1'b0);
  endtask

  task automatic rd_hit(input int u, input logic [31:0] a, input logic [31:0] d);
    access(u, 1'b0, a, 32'h0, 1'b1, d, 1'b0, 32'h0, 32'h0, 1'b0, 0);
  endtask

  task automatic rd_miss(input int u, input logic [31:0] a, input logic [31:0] d, input int stall);
    access(u, 1'b0, a, 32'h0, 1'b0, d, 1'b0, 32'h0, 32'h0, 1'b1, stall);
  endtask

  task automatic wr(input int u, input logic [31:0] a, input logic [31:0] d, input bit hit);
    access(u, 1'b1, a, d, hit, d, 1'b0, 32'h0, 32'h0, 1'b0, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1);
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1;
      req_valid[u] = 1'b0;
      req_we[u] = 1'b0;
      req_addr[u] = 32'h0;
      req_wdata[u] = 32'h0;
      mem_req_ready[u] = 1'b0;
      mem_resp_valid[u] = 1'b0;
      mem_resp_rdata[u] = 32'h0;
    end
    @(negedge clk);
    check_idle_outputs(0, "reset0");
    check_idle_outputs(1, "reset1");
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Basic refill then hit
    rd_miss(0, 32'h100, 32'hDEAD_BEEF, 0);
    rd_hit(0, 32'h100, 32'hDEAD_BEEF);

    // Fill set 0, then PLRU chooses way 2 (0x020)
    do_reset(0);
    rd_miss(0, 32'h000, mv(32'h000), 0);
    rd_miss(0, 32'h010, mv(32'h010), 0);
    rd_miss(0, 32'h020, mv(32'h020), 0);
    rd_miss(0, 32'h030, mv(32'h030), 0);
    rd_hit(0, 32'h000, mv(32'h000));
    rd_miss(0, 32'h040, mv(32'h040), 0);
    rd_hit(0, 32'h010, mv(32'h010));
    rd_miss(0, 32'h020, mv(32'h020), 0);

    // Write allocate without fetch, dirty eviction, write hit
    do_reset(0);
    wr(0, 32'h000, 32'hA5A5_A5A5, 1'b0);
    rd_miss(0, 32'h010, mv(32'h010), 0);
    rd_miss(0, 32'h020, mv(32'h020), 0);
    rd_miss(0, 32'h030, mv(32'h030), 0);
    access(0, 1'b0, 32'h040, 32'h0, 1'b0, mv(32'h040), 1'b1, 32'h000, 32'hA5A5_A5A5, 1'b1, 0);
    wr(0, 32'h010, 32'h1234_5678, 1'b1);
    rd_hit(0, 32'h010, 32'h1234_5678);

    // Refill request stalled for 5 cycles
    do_reset(0);
    rd_miss(0, 32'h200, mv(32'h200), 5);
    rd_hit(0, 32'h200, mv(32'h200));

    // Reset while the refill request is pending
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b0;
    req_addr[0]  = 32'h300;
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    check_eq("pre_reset_mreq", mem_req_valid[0], 1'b1);
    #2 rst[0] = 1'b1;
    #1 check_idle_outputs(0, "mid_fill_reset");
    @(negedge clk);
    rst[0] = 1'b0;
    mem_resp_valid[0] = 1'b1;
    mem_resp_rdata[0] = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_resp_valid[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("late_resp_ignored", {resp_valid[0], mem_req_valid[0], req_ready[0]}, 3'b001);
      @(negedge clk);
    end
    rd_miss(0, 32'h200, mv(32'h200), 0);

    // 8 sets x 2 ways: index = addr[4:2]
    rd_miss(1, 32'h100, 32'hDEAD_BEEF, 0);
    rd_hit(1, 32'h100, 32'hDEAD_BEEF);
    rd_miss(1, 32'h000, mv(32'h000), 0);
    rd_miss(1, 32'h010, mv(32'h010), 0);
    rd_hit(1, 32'h100, 32'hDEAD_BEEF);
    rd_hit(1, 32'h000, mv(32'h000));
    rd_miss(1, 32'h020, mv(32'h020), 0);
    rd_hit(1, 32'h000, mv(32'h000));
    rd_hit(1, 32'h010, mv(32'h010));
    rd_miss(1, 32'h100, mv(32'h100), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
